// File: rtl/hex_word_packer_pkg.sv
// Shared types and constants for the HEX byte-to-word packer.
package hex_pack_pkg;

  localparam int WORD_ADDR_W = 14;
  localparam int LANES = 4;
  localparam logic [LANES-1:0] BE_FULL = 4'hF;

  // One buffered word: word address, byte enables and little-endian data.
  typedef struct packed {
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [LANES-1:0]       be;
    logic [8*LANES-1:0]     data;
  } fifo_entry_t;

  // Replace one byte lane of a word, leaving the other lanes untouched.
  function automatic logic [31:0] mergeLane(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  byteVal);
    logic [31:0] result;
    result = word;
    result[{lane, 3'b000} +: 8] = byteVal;
    return result;
  endfunction

  // Byte-enable bit for a single lane.
  function automatic logic [3:0] laneOnehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/hex_word_packer_if.sv
// Byte-write stream in, word-write stream out of the HEX packer.
interface hex_word_packer_if;
  import hex_pack_pkg::*;

  logic                   in_wr_en;
  logic [15:0]            in_addr;
  logic [7:0]             in_data;
  logic                   flush;

  logic                   mem_valid;
  logic                   mem_ready;
  logic [WORD_ADDR_W-1:0] mem_word_addr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_be;

  // The packer: consumes bytes, drives the RAM write port.
  modport master (
    input  in_wr_en, in_addr, in_data, flush, mem_ready,
    output mem_valid, mem_word_addr, mem_wdata, mem_be
  );

  // The surroundings: HEX parser and RAM arbiter.
  modport slave (
    output in_wr_en, in_addr, in_data, flush, mem_ready,
    input  mem_valid, mem_word_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/hex_word_packer_fifo.sv
// First-word-fall-through FIFO of packed words; head is zero while empty.
module byte_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 50
) (
  input  logic             clk_74a,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wrPtr_q;
  logic [PTR_W:0]   rdPtr_q;
  logic [WIDTH-1:0] store_q [DEPTH];
  logic             wrEn;
  logic             rdEn;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign rdEn    = pop_i && !empty_o;
  assign wrEn    = push_i && (!full_o || rdEn);
  assign head_o  = empty_o ? '0 : store_q[rdPtr_q[PTR_W-1:0]];

  // Pointer update; a full FIFO still accepts a push when the head leaves the same cycle.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (wrEn) wrPtr_q <= wrPtr_q + {{PTR_W{1'b0}}, 1'b1};
      if (rdEn) rdPtr_q <= rdPtr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Entry storage, cleared on reset so no stale word can reappear.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else if (wrEn) begin
      store_q[wrPtr_q[PTR_W-1:0]] <= pushData_i;
    end
  end

endmodule

// File: rtl/hex_word_packer.sv
// Packs decoded HEX byte writes into 32-bit little-endian words for the core RAM.
module hex_word_packer
  import hex_pack_pkg::*;
#(
  parameter int FIFO_DEPTH        = 4,
  parameter int IDLE_FLUSH_CYCLES = 1024
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  hex_word_packer_if.master  pack_if,
  output logic               busy_o,
  output logic               overflow_o,
  output logic [15:0]        words_written_o
);

  localparam int IDLE_W = $clog2(IDLE_FLUSH_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FLUSH_CYCLES - 1);

  logic                   active_q, active_d;
  logic [WORD_ADDR_W-1:0] curWord_q, curWord_d;
  logic [31:0]            data_q, data_d;
  logic [3:0]             be_q, be_d;
  logic                   flushPending_q, flushPending_d;
  logic [IDLE_W-1:0]      idleCnt_q, idleCnt_d;
  logic                   overflow_q;
  logic [15:0]            wordsWritten_q;

  logic [WORD_ADDR_W-1:0] inWord;
  logic [1:0]             lane;
  logic [31:0]            mergedData;
  logic [3:0]             mergedBe;
  logic                   effFlush;
  logic                   push;
  fifo_entry_t            pushEntry;
  fifo_entry_t            headEntry;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic                   pop;

  // Assembly, flush and idle-timeout decisions; produces at most one push per cycle.
  always_comb begin
    inWord         = pack_if.in_addr[15:2];
    lane           = pack_if.in_addr[1:0];
    mergedData     = mergeLane(active_q ? data_q : 32'h0, lane, pack_if.in_data);
    mergedBe       = (active_q ? be_q : 4'h0) | laneOnehot(lane);
    effFlush       = pack_if.flush || flushPending_q;
    active_d       = active_q;
    curWord_d      = curWord_q;
    data_d         = data_q;
    be_d           = be_q;
    flushPending_d = flushPending_q;
    idleCnt_d      = idleCnt_q;
    push           = 1'b0;
    pushEntry      = '{word_addr: curWord_q, be: be_q, data: data_q};

    if (pack_if.in_wr_en) begin
      idleCnt_d      = '0;
      flushPending_d = 1'b0;
      if (!active_q || inWord == curWord_q) begin
        pushEntry = '{word_addr: inWord, be: mergedBe, data: mergedData};
        if (mergedBe == BE_FULL || effFlush) begin
          push           = 1'b1;
          active_d       = 1'b0;
          data_d         = 32'h0;
          be_d           = 4'h0;
          flushPending_d = (mergedBe == BE_FULL) && effFlush;
        end else begin
          active_d  = 1'b1;
          curWord_d = inWord;
          data_d    = mergedData;
          be_d      = mergedBe;
        end
      end else begin
        push           = 1'b1;
        active_d       = 1'b1;
        curWord_d      = inWord;
        data_d         = mergeLane(32'h0, lane, pack_if.in_data);
        be_d           = laneOnehot(lane);
        flushPending_d = effFlush;
      end
    end else if (active_q) begin
      if (effFlush || idleCnt_q == IDLE_LAST) begin
        push           = 1'b1;
        active_d       = 1'b0;
        data_d         = 32'h0;
        be_d           = 4'h0;
        idleCnt_d      = '0;
        flushPending_d = 1'b0;
      end else begin
        idleCnt_d = idleCnt_q + IDLE_W'(1);
      end
    end else begin
      flushPending_d = 1'b0;
    end
  end

  // Assembly register, pending flush and idle counter.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      active_q       <= 1'b0;
      curWord_q      <= '0;
      data_q         <= 32'h0;
      be_q           <= 4'h0;
      flushPending_q <= 1'b0;
      idleCnt_q      <= '0;
    end else begin
      active_q       <= active_d;
      curWord_q      <= curWord_d;
      data_q         <= data_d;
      be_q           <= be_d;
      flushPending_q <= flushPending_d;
      idleCnt_q      <= idleCnt_d;
    end
  end

  byte_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_74a    (clk_74a),
    .reset_n    (reset_n),
    .push_i     (push),
    .pushData_i (pushEntry),
    .pop_i      (pop),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .head_o     (headEntry)
  );

  assign pop                   = !fifoEmpty && pack_if.mem_ready;
  assign pack_if.mem_valid     = !fifoEmpty;
  assign pack_if.mem_word_addr = headEntry.word_addr;
  assign pack_if.mem_wdata     = headEntry.data;
  assign pack_if.mem_be        = headEntry.be;

  // Sticky drop flag and a wrapping count of words handed to the RAM.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q     <= 1'b0;
      wordsWritten_q <= 16'h0;
    end else begin
      if (push && fifoFull && !pop) overflow_q <= 1'b1;
      if (pop) wordsWritten_q <= wordsWritten_q + 16'd1;
    end
  end

  assign busy_o          = active_q || flushPending_q || !fifoEmpty;
  assign overflow_o      = overflow_q;
  assign words_written_o = wordsWritten_q;

endmodule

// File: tb/tb_hex_word_packer.sv
// Scoreboard bench for hex_word_packer: directed byte streams, queued expected words.
module tb_hex_word_packer;
  import hex_pack_pkg::*;

  localparam int FIFO_DEPTH        = 4;
  localparam int IDLE_FLUSH_CYCLES = 1024;

  logic        clk_74a = 1'b0;
  logic        reset_n;
  logic        busy;
  logic        overflow;
  logic [15:0] wordsWritten;

  logic [49:0] expQ [$];
  int          vectorCount = 0;
  int          missCount   = 0;
  int          expWritten  = 0;

  hex_word_packer_if packIf ();

  hex_word_packer #(
    .FIFO_DEPTH        (FIFO_DEPTH),
    .IDLE_FLUSH_CYCLES (IDLE_FLUSH_CYCLES)
  ) dut (
    .clk_74a         (clk_74a),
    .reset_n         (reset_n),
    .pack_if         (packIf),
    .busy_o          (busy),
    .overflow_o      (overflow),
    .words_written_o (wordsWritten)
  );

  always #5 clk_74a = ~clk_74a;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectWord(input logic [13:0] addr, input logic [3:0] be, input logic [31:0] data);
    expQ.push_back({addr, be, data});
    expWritten++;
  endtask

  // One byte write (optionally with flush) held for exactly one sampling edge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic fl);
    @(posedge clk_74a); #1;
    packIf.in_wr_en = 1'b1;
    packIf.in_addr  = addr;
    packIf.in_data  = data;
    packIf.flush    = fl;
    @(posedge clk_74a); #1;
    packIf.in_wr_en = 1'b0;
    packIf.flush    = 1'b0;
  endtask

  task automatic pulseFlush();
    @(posedge clk_74a); #1;
    packIf.flush = 1'b1;
    @(posedge clk_74a); #1;
    packIf.flush = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk_74a);
      n++;
    end
    #1;
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: every RAM handshake must match the oldest expected word.
  always @(negedge clk_74a) begin
    logic [49:0] got;
    logic [49:0] exp;
    if (packIf.mem_valid === 1'b1 && packIf.mem_ready === 1'b1) begin
      got = {packIf.mem_word_addr, packIf.mem_be, packIf.mem_wdata};
      if (expQ.size() == 0) begin
        vectorCount++;
        missCount++;
        $display("[TB] FAIL unexpected word: got %0h, expected none", got);
      end else begin
        exp = expQ.pop_front();
        checkOutput("mem word {addr,be,data}", 64'(got), 64'(exp));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] stallData [5];
    int          n;
    stallData = '{32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140, 32'h53525150};

    reset_n          = 1'b0;
    packIf.in_wr_en  = 1'b0;
    packIf.in_addr   = 16'h0;
    packIf.in_data   = 8'h0;
    packIf.flush     = 1'b0;
    packIf.mem_ready = 1'b0;
    repeat (3) @(posedge clk_74a);
    #1;
    checkOutput("reset mem_valid", 64'(packIf.mem_valid), 64'd0);
    checkOutput("reset mem_word_addr", 64'(packIf.mem_word_addr), 64'd0);
    checkOutput("reset mem_wdata", 64'(packIf.mem_wdata), 64'd0);
    checkOutput("reset mem_be", 64'(packIf.mem_be), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    checkOutput("reset words_written", 64'(wordsWritten), 64'd0);
    reset_n = 1'b1;

    // Full word from four sequential bytes.
    packIf.mem_ready = 1'b1;
    applyStimulus(16'h0000, 8'h13, 1'b0);
    applyStimulus(16'h0001, 8'h05, 1'b0);
    applyStimulus(16'h0002, 8'h00, 1'b0);
    checkOutput("no push before 4th byte", 64'(packIf.mem_valid), 64'd0);
    expectWord(14'h0000, 4'hF, 32'h00000513);
    applyStimulus(16'h0003, 8'h00, 1'b0);
    checkOutput("valid after 4th byte", 64'(packIf.mem_valid), 64'd1);
    waitDrain("drain full word");
    checkOutput("words_written after 1 word", 64'(wordsWritten), 64'd1);

    // Word change pushes the old partial word, flush pushes the new one.
    expectWord(14'h0004, 4'b0001, 32'h000000AA);
    expectWord(14'h0008, 4'b0001, 32'h000000BB);
    applyStimulus(16'h0010, 8'hAA, 1'b0);
    applyStimulus(16'h0020, 8'hBB, 1'b0);
    pulseFlush();
    waitDrain("drain word change + flush");

    // Idle timeout on a lone high-lane byte.
    expectWord(14'h0001, 4'b1000, 32'h5C000000);
    applyStimulus(16'h0007, 8'h5C, 1'b0);
    checkOutput("busy with partial word", 64'(busy), 64'd1);
    n = 0;
    while (packIf.mem_valid !== 1'b1 && n < IDLE_FLUSH_CYCLES + 100) begin
      @(posedge clk_74a); #1;
      n++;
    end
    checkOutput("idle flush latency", 64'(n), 64'(IDLE_FLUSH_CYCLES));
    waitDrain("drain idle flush");

    // Flush arriving with a word-changing write: two pushes on consecutive cycles.
    expectWord(14'h0040, 4'b0001, 32'h00000011);
    expectWord(14'h0041, 4'b0001, 32'h00000022);
    applyStimulus(16'h0100, 8'h11, 1'b0);
    applyStimulus(16'h0104, 8'h22, 1'b1);
    checkOutput("old word at head", 64'(packIf.mem_word_addr), 64'h40);
    checkOutput("busy during flush", 64'(busy), 64'd1);
    @(posedge clk_74a); #1;
    checkOutput("pending word at head", 64'(packIf.mem_word_addr), 64'h41);
    checkOutput("busy before last pop", 64'(busy), 64'd1);
    @(posedge clk_74a); #1;
    checkOutput("busy falls after drain", 64'(busy), 64'd0);
    checkOutput("empty after drain", 64'(packIf.mem_valid), 64'd0);

    // Stalled RAM: four words fit, the fifth is dropped.
    packIf.mem_ready = 1'b0;
    for (int w = 0; w < 5; w++) begin
      if (w == 4) checkOutput("no overflow at 4 words", 64'(overflow), 64'd0);
      if (w < 4) expectWord(14'h0080 + 14'(w), 4'hF, stallData[w]);
      for (int l = 0; l < 4; l++)
        applyStimulus(16'h0200 + 16'(4 * w + l), stallData[w][8*l +: 8], 1'b0);
    end
    checkOutput("overflow after 5th word", 64'(overflow), 64'd1);
    repeat (3) @(posedge clk_74a);
    #1;
    checkOutput("head stable while stalled", {packIf.mem_word_addr, packIf.mem_be, packIf.mem_wdata},
                {14'h0080, 4'hF, 32'h13121110});
    packIf.mem_ready = 1'b1;
    waitDrain("drain after stall");
    checkOutput("words_written total", 64'(wordsWritten), 64'(expWritten));
    checkOutput("overflow sticky", 64'(overflow), 64'd1);

    // Asynchronous reset mid-load discards everything.
    packIf.mem_ready = 1'b0;
    for (int l = 0; l < 8; l++) applyStimulus(16'h0300 + 16'(l), 8'(8'h60 + l), 1'b0);
    applyStimulus(16'h0308, 8'h77, 1'b0);
    checkOutput("valid before reset", 64'(packIf.mem_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset mem_valid", 64'(packIf.mem_valid), 64'd0);
    checkOutput("async reset data", {packIf.mem_word_addr, packIf.mem_be, packIf.mem_wdata}, 64'd0);
    checkOutput("async reset busy", 64'(busy), 64'd0);
    checkOutput("async reset overflow", 64'(overflow), 64'd0);
    checkOutput("async reset words_written", 64'(wordsWritten), 64'd0);
    #20;
    reset_n = 1'b1;
    packIf.mem_ready = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk_74a);
      if (packIf.mem_valid !== 1'b0) n++;
    end
    checkOutput("no valid after reset", 64'(n), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/hex_word_packer.md
# hex_word_packer

Downstream stage of the Intel-HEX ROM loader. It takes the loader's decoded byte-write stream (8-bit data, 16-bit byte address) and packs it into 32-bit little-endian words with byte enables. Words are buffered in a small FIFO and presented to the RISC-V instruction/data RAM write port with a valid/ready handshake. It runs in the clk_74a domain, between the HEX parser and the core memory arbiter.

## Interface
- FIFO_DEPTH, 4: word FIFO entries (power of two, ≥2)
- IDLE_FLUSH_CYCLES, 1024: idle cycles before a partial word is auto-flushed (≥2)
- clk_74a  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_wr_en  in  1  byte write strobe from the HEX parser, single-cycle
- in_addr  in  16  byte address
- in_data  in  8  byte value
- flush  in  1  pulse: load complete, emit any partial word
- mem_valid  out  1  FIFO head valid
- mem_ready  in  1  RAM port accepts the head this cycle
- mem_word_addr  out  14  word address (in_addr[15:2])
- mem_wdata  out  32  word data, lane k = bits [8k+7:8k]
- mem_be  out  4  byte enables
- busy  out  1  partial word, pending flush, or non-empty FIFO
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- words_written  out  16  count of accepted mem handshakes, wraps

## Operation
- Assembly register holds: active, cur_word (14b), data (32b), be (4b). lane = in_addr[1:0], word = in_addr[15:2].
- in_wr_en, and either not active or word == cur_word: merge the byte into the lane and set be[lane]. A repeated lane overwrites that lane's data and keeps be. If the merged be == 4'hF, push the word to the FIFO this cycle and clear active. Otherwise set active and cur_word = word.
- in_wr_en, active, word != cur_word: push the old word. Start a new word containing only this byte (be = one-hot lane).
- At most one push per cycle.
- flush with active and no in_wr_en: push the partial word and clear active.
- flush with an in_wr_en that itself pushes a word: set flush_pending. The remaining partial word, if any, is pushed the next cycle.
- flush with an in_wr_en to the same word that does not complete it: merge, then push in the same cycle.
- flush with nothing active: no effect.
- Idle counter: reset on every in_wr_en; counts while active. On reaching IDLE_FLUSH_CYCLES-1, push the partial word and clear active.
- Push when the FIFO is full and no pop occurs that cycle: the word is dropped, overflow is set, and the assembly register is cleared as normal. Push on a full FIFO with a simultaneous pop is accepted.
- FIFO is first-word-fall-through. mem_valid = !empty. A pop happens when mem_valid && mem_ready; words_written increments on each pop.
- mem_* are stable while mem_valid && !mem_ready.
- overflow clears only on reset.

## Timing
- Reset values: mem_valid 0, mem_word_addr 0, mem_wdata 0, mem_be 0, busy 0, overflow 0, words_written 0. Reset also clears the assembly register, idle counter, flush_pending, FIFO pointers and FIFO storage.
- Reset is asynchronous and may assert mid-load. All state clears immediately, nothing is emitted, and partial words are lost.
- Latency: a push caused by the input sampled at edge N makes mem_valid high after edge N. With the FIFO empty, the word is at the head in the next cycle.
- Throughput: one push and one pop per cycle.
- busy falls in the first cycle after the last pop with nothing active or pending.
- words_written wraps 16'hFFFF -> 0.

## Structure
- Package hex_pack_pkg: WORD_ADDR_W = 14, LANES = 4, BE_FULL = 4'hF, and the packed FIFO entry typedef {word_addr[13:0], be[3:0], data[31:0]} (50 bits).
- Sub-module byte_word_fifo: synchronous FWFT FIFO, parameterised by depth and entry width. It exposes push, pop, full, empty, and the head entry. The packer contains the assembly, idle and flush logic.

## Test plan
- Bytes 0x13,0x05,0x00,0x00 at addresses 0x0000..0x0003 with mem_ready=1: one word, mem_word_addr=0, mem_wdata=32'h00000513, mem_be=4'hF, pushed at the 4th byte, words_written=1.
- Bytes at 0x0010 (0xAA) then 0x0020 (0xBB), then flush: word 4 (be=4'b0001, data 0x000000AA), then word 8 (be=4'b0001, data 0x000000BB).
- Single byte at 0x0007 (0x5C), no further input: after IDLE_FLUSH_CYCLES cycles, word 1 with be=4'b1000 and data 32'h5C000000.
- mem_ready=0, then 5 full words with FIFO_DEPTH=4: first 4 retained in order, overflow=1, 5th dropped. Releasing ready drains 4 words and words_written=4.
- Byte to 0x0104 with flush in the same cycle while word 0x40 is partial: word 0x40 pushed, then word 0x41 pushed the next cycle. busy falls after the drain.
- reset_n pulsed low while the FIFO holds 2 words and 1 partial word: all outputs return to reset values asynchronously and no further mem_valid occurs.
